// File: rtl/x_ramb_pkg.sv
// x_ramb_pkg: write-mode encodings, clear FSM states and elaboration-time helpers for x_ramb_asym_tdp
package x_ramb_pkg;
  localparam logic [1:0] WRITE_FIRST = 2'b00;
  localparam logic [1:0] READ_FIRST = 2'b01;
  localparam logic [1:0] NO_CHANGE = 2'b10;
  localparam logic [1:0] MODE_BAD = 2'b11;
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  // Port B must be a power-of-two multiple of port A.
  function automatic bit ratio_ok(input int dw_a, input int dw_b);
    return dw_a > 0 && dw_b >= dw_a && dw_b % dw_a == 0 && (1 << clog2(dw_b / dw_a)) == dw_b / dw_a;
  endfunction
endpackage

// File: rtl/x_ramb_asym_tdp_if.sv
// x_ramb_asym_tdp_if: two-port RAM bus
// master drives ENA/WEA/SSRA/ADDRA/DIA and ENB/WEB/SSRB/ADDRB/DIB; slave returns DOA/DOB, BUSY, COLL
interface x_ramb_asym_tdp_if #(
  parameter int AW_A = 14,
  parameter int DW_A = 1,
  parameter int DW_B = 2
);
  import x_ramb_pkg::*;
  localparam int AW_B = AW_A - clog2(DW_B / DW_A);
  logic ENA, WEA, SSRA;
  logic [AW_A-1:0] ADDRA;
  logic [DW_A-1:0] DIA, DOA;
  logic ENB, WEB, SSRB;
  logic [AW_B-1:0] ADDRB;
  logic [DW_B-1:0] DIB, DOB;
  logic BUSY, COLL;
  modport master(output ENA, WEA, SSRA, ADDRA, DIA, ENB, WEB, SSRB, ADDRB, DIB, input DOA, DOB, BUSY, COLL);
  modport slave(input ENA, WEA, SSRA, ADDRA, DIA, ENB, WEB, SSRB, ADDRB, DIB, output DOA, DOB, BUSY, COLL);
endinterface

// File: rtl/x_ramb_clear_seq.sv
// x_ramb_clear_seq: post-reset sweep writing zero to every port A word
// Ports: i_clk, i_rst_n (async active-low); o_busy (sweep running), o_clr_addr (word being cleared), o_clr_we (clear strobe)
module x_ramb_clear_seq import x_ramb_pkg::*; #(
  parameter int AW = 14,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic i_clk,
  input logic i_rst_n,
  output logic o_busy,
  output logic [AW-1:0] o_clr_addr,
  output logic o_clr_we
);
  clr_state_t r_state, w_state_nx;
  logic [AW-1:0] r_cnt, w_cnt_nx;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
    end
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt;
    if (r_state == CLEAR) begin
      w_cnt_nx = r_cnt + 1'b1;
      w_state_nx = &r_cnt ? IDLE : CLEAR;
    end
  end
  assign o_busy = r_state == CLEAR;
  assign o_clr_we = o_busy;
  assign o_clr_addr = r_cnt;
endmodule

// File: rtl/x_ramb_asym_tdp.sv
// x_ramb_asym_tdp: single-clock true-dual-port RAM, one array seen as DW_A-bit words (A) and DW_B-bit words (B)
// Ports: CLK, RST_N (async active-low); bus (slave modport): port A/B requests, DOA/DOB read data,
//        BUSY (clear sweep running, requests ignored), COLL (collision in the previous cycle)
module x_ramb_asym_tdp import x_ramb_pkg::*; #(
  parameter int AW_A = 14,
  parameter int DW_A = 1,
  parameter int DW_B = 2,
  parameter string WRITE_MODE_A = "WRITE_FIRST",
  parameter string WRITE_MODE_B = "WRITE_FIRST",
  parameter logic [DW_A-1:0] SRVAL_A = '0,
  parameter logic [DW_B-1:0] SRVAL_B = '0,
  parameter bit DO_REG = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic CLK,
  input logic RST_N,
  x_ramb_asym_tdp_if.slave bus
);
  localparam int K = clog2(DW_B / DW_A);
  localparam int R = 2 ** K;
  localparam logic [1:0] MODE_A = WRITE_MODE_A == "WRITE_FIRST" ? WRITE_FIRST : WRITE_MODE_A == "READ_FIRST" ? READ_FIRST :
                                  WRITE_MODE_A == "NO_CHANGE" ? NO_CHANGE : MODE_BAD;
  localparam logic [1:0] MODE_B = WRITE_MODE_B == "WRITE_FIRST" ? WRITE_FIRST : WRITE_MODE_B == "READ_FIRST" ? READ_FIRST :
                                  WRITE_MODE_B == "NO_CHANGE" ? NO_CHANGE : MODE_BAD;
  if (!ratio_ok(DW_A, DW_B)) begin : g_bad_ratio
    $error("x_ramb_asym_tdp: DW_B must be DW_A times a power of two");
  end
  if (MODE_A == MODE_BAD || MODE_B == MODE_BAD) begin : g_bad_mode
    $error("x_ramb_asym_tdp: WRITE_MODE must be WRITE_FIRST, READ_FIRST or NO_CHANGE");
  end
  logic [DW_A-1:0] mem [2**AW_A];
  logic w_busy, w_clr_we, w_ena, w_enb, w_coll;
  logic [AW_A-1:0] w_clr_addr, w_base_b;
  logic [DW_A-1:0] w_rd_a, w_s1a_nx, r_s1a, r_s2a;
  logic [DW_B-1:0] w_rd_b, w_s1b_nx, r_s1b, r_s2b;
  logic r_coll;
  x_ramb_clear_seq #(.AW(AW_A), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_clr (
    .i_clk(CLK),
    .i_rst_n(RST_N),
    .o_busy(w_busy),
    .o_clr_addr(w_clr_addr),
    .o_clr_we(w_clr_we)
  );
  assign w_ena = bus.ENA & ~w_busy;
  assign w_enb = bus.ENB & ~w_busy;
  // Port B word j spans port A words j*R .. j*R+R-1, lowest A word in the lowest bits.
  assign w_base_b = AW_A'(bus.ADDRB) << K;
  assign w_rd_a = mem[bus.ADDRA];
  for (genvar i = 0; i < R; i++) begin : g_rd_b
    assign w_rd_b[i*DW_A +: DW_A] = mem[w_base_b | AW_A'(i)];
  end
  assign w_coll = w_ena & w_enb & (bus.WEA | bus.WEB) & ((bus.ADDRA >> K) == AW_A'(bus.ADDRB));
  // Port A write is issued last so it wins on the shared bits of a write/write collision.
  always_ff @(posedge CLK) begin
    if (w_clr_we) mem[w_clr_addr] <= '0;
    if (w_enb && bus.WEB) for (int i = 0; i < R; i++) mem[w_base_b | AW_A'(i)] <= bus.DIB[i*DW_A +: DW_A];
    if (w_ena && bus.WEA) mem[bus.ADDRA] <= bus.DIA;
  end
  // Reads see the array before this edge's writes, which gives READ_FIRST and the pre-write collision data.
  assign w_s1a_nx = !w_ena ? r_s1a : bus.SSRA ? SRVAL_A : (!bus.WEA || MODE_A == READ_FIRST) ? w_rd_a :
                    MODE_A == WRITE_FIRST ? bus.DIA : r_s1a;
  assign w_s1b_nx = !w_enb ? r_s1b : bus.SSRB ? SRVAL_B : (!bus.WEB || MODE_B == READ_FIRST) ? w_rd_b :
                    MODE_B == WRITE_FIRST ? bus.DIB : r_s1b;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_s1a <= '0;
      r_s1b <= '0;
      r_s2a <= '0;
      r_s2b <= '0;
      r_coll <= 1'b0;
    end else begin
      r_s1a <= w_s1a_nx;
      r_s1b <= w_s1b_nx;
      r_s2a <= r_s1a;
      r_s2b <= r_s1b;
      r_coll <= w_coll;
    end
  assign bus.DOA = DO_REG ? r_s2a : r_s1a;
  assign bus.DOB = DO_REG ? r_s2b : r_s1b;
  assign bus.BUSY = w_busy;
  assign bus.COLL = r_coll;
endmodule

// File: tb/tb_x_ramb_asym_tdp.sv
// tb_x_ramb_asym_tdp: three RAM variants (different write modes, SRVALs, DO_REG) driven in lockstep
module tb_x_ramb_asym_tdp;
  typedef struct packed {
    logic ena, wea, ssra;
    logic [3:0] addra;
    logic dia;
    logic enb, web, ssrb;
    logic [2:0] addrb;
    logic [1:0] dib;
  } in_t;
  typedef struct {in_t i; logic xa; logic [1:0] xb; logic xc;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t cur = '0;
  int total = 0, bad = 0;
  logic [2:0] doa_q, busy_q, coll_q;
  logic [1:0] dob_q [3];
  always #5 clk = ~clk;
  x_ramb_asym_tdp_if #(.AW_A(4), .DW_A(1), .DW_B(2)) ifc [3] ();
  for (genvar g = 0; g < 3; g++) begin : g_drv
    assign ifc[g].ENA = cur.ena;
    assign ifc[g].WEA = cur.wea;
    assign ifc[g].SSRA = cur.ssra;
    assign ifc[g].ADDRA = cur.addra;
    assign ifc[g].DIA = cur.dia;
    assign ifc[g].ENB = cur.enb;
    assign ifc[g].WEB = cur.web;
    assign ifc[g].SSRB = cur.ssrb;
    assign ifc[g].ADDRB = cur.addrb;
    assign ifc[g].DIB = cur.dib;
    assign doa_q[g] = ifc[g].DOA;
    assign dob_q[g] = ifc[g].DOB;
    assign busy_q[g] = ifc[g].BUSY;
    assign coll_q[g] = ifc[g].COLL;
  end
  x_ramb_asym_tdp #(.AW_A(4), .DW_A(1), .DW_B(2), .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("NO_CHANGE"),
    .SRVAL_A(1'b1), .SRVAL_B(2'b01), .DO_REG(1'b0), .CLEAR_ON_RESET(1'b1)) u0 (.CLK(clk), .RST_N(rst_n), .bus(ifc[0]));
  x_ramb_asym_tdp #(.AW_A(4), .DW_A(1), .DW_B(2), .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
    .SRVAL_A(1'b0), .SRVAL_B(2'b10), .DO_REG(1'b1), .CLEAR_ON_RESET(1'b1)) u1 (.CLK(clk), .RST_N(rst_n), .bus(ifc[1]));
  x_ramb_asym_tdp #(.AW_A(4), .DW_A(1), .DW_B(2), .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST"),
    .SRVAL_A(1'b1), .SRVAL_B(2'b11), .DO_REG(1'b0), .CLEAR_ON_RESET(1'b1)) u2 (.CLK(clk), .RST_N(rst_n), .bus(ifc[2]));
  // Reference model: 0=WRITE_FIRST 1=READ_FIRST 2=NO_CHANGE; the array is a flat 16-bit vector.
  int mode_a [3] = '{0, 1, 2};
  int mode_b [3] = '{2, 0, 1};
  bit sr_a [3] = '{1'b1, 1'b0, 1'b1};
  bit [1:0] sr_b [3] = '{2'b01, 2'b10, 2'b11};
  bit doreg [3] = '{1'b0, 1'b1, 1'b0};
  bit [15:0] m_mem [3];
  bit m_s1a [3], m_s2a [3], m_coll [3], m_busy [3];
  bit [1:0] m_s1b [3], m_s2b [3];
  int m_cnt [3];
  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_s1a[d] = 0; m_s2a[d] = 0; m_s1b[d] = 0; m_s2b[d] = 0;
      m_coll[d] = 0; m_busy[d] = 1; m_cnt[d] = 0;
    end
  endtask
  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      bit oa;
      bit [1:0] ob;
      m_s2a[d] = m_s1a[d];
      m_s2b[d] = m_s1b[d];
      m_coll[d] = 0;
      if (m_busy[d]) begin
        m_mem[d][m_cnt[d]] = 0;
        m_cnt[d]++;
        m_busy[d] = m_cnt[d] < 16;
      end else begin
        oa = m_mem[d][cur.addra];
        ob = {m_mem[d][2*cur.addrb+1], m_mem[d][2*cur.addrb]};
        if (cur.ena) m_s1a[d] = cur.ssra ? sr_a[d] : !cur.wea ? oa : mode_a[d] == 0 ? cur.dia : mode_a[d] == 1 ? oa : m_s1a[d];
        if (cur.enb) m_s1b[d] = cur.ssrb ? sr_b[d] : !cur.web ? ob : mode_b[d] == 0 ? cur.dib : mode_b[d] == 1 ? ob : m_s1b[d];
        if (cur.enb && cur.web) begin
          m_mem[d][2*cur.addrb] = cur.dib[0];
          m_mem[d][2*cur.addrb+1] = cur.dib[1];
        end
        if (cur.ena && cur.wea) m_mem[d][cur.addra] = cur.dia;
        m_coll[d] = cur.ena && cur.enb && (cur.wea || cur.web) && (cur.addra / 2 == cur.addrb);
      end
    end
  endtask
  task automatic cmp(input string nm, input int d, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h t=%0t", nm, d, act, exp, $time);
    end
  endtask
  task automatic check_model();
    for (int d = 0; d < 3; d++) begin
      cmp("doa", d, 8'(doa_q[d]), 8'(doreg[d] ? m_s2a[d] : m_s1a[d]));
      cmp("dob", d, 8'(dob_q[d]), 8'(doreg[d] ? m_s2b[d] : m_s1b[d]));
      cmp("coll", d, 8'(coll_q[d]), 8'(m_coll[d]));
      cmp("busy", d, 8'(busy_q[d]), 8'(m_busy[d]));
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_model();
  endtask
  task automatic count_busy();
    int n = 0;
    do begin
      cyc();
      n++;
    end while (busy_q[0] && n < 40);
    cmp("busy_len", 0, 8'(n), 8'd16);
  endtask
  task automatic read_all_b();
    for (int j = 0; j < 8; j++) begin
      cur = '0;
      cur.enb = 1;
      cur.addrb = 3'(j);
      cyc();
      cmp("clr_rd_b", 0, 8'(dob_q[0]), 8'd0);
    end
  endtask
  function automatic vec_t mk(input bit a_en, a_we, a_ssr, input int a_ad, input bit a_di,
                              input bit b_en, b_we, b_ssr, input int b_ad, input int b_di,
                              input bit xa, input int xb, input bit xc);
    vec_t v;
    v.i = '{a_en, a_we, a_ssr, 4'(a_ad), a_di, b_en, b_we, b_ssr, 3'(b_ad), 2'(b_di)};
    v.xa = xa;
    v.xb = 2'(xb);
    v.xc = xc;
    return v;
  endfunction
  initial begin
    vec_t tbl [15];
    // Expected values are for u0 (A WRITE_FIRST, B NO_CHANGE, SRVAL_A=1, SRVAL_B=01, no output register).
    tbl[0] = mk(1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[1] = mk(1, 1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 2, 0);
    tbl[3] = mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    tbl[4] = mk(1, 1, 0, 7, 1, 1, 1, 0, 3, 0, 1, 2, 1);
    tbl[5] = mk(0, 0, 0, 0, 0, 1, 0, 0, 3, 0, 1, 2, 0);
    tbl[6] = mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    tbl[7] = mk(1, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 2, 0);
    tbl[8] = mk(1, 0, 0, 2, 0, 1, 1, 0, 1, 3, 0, 2, 1);
    tbl[9] = mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 1, 1, 4, 1, 1, 1, 0);
    tbl[11] = mk(1, 0, 0, 8, 0, 1, 0, 0, 4, 0, 1, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[13] = mk(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1);
    tbl[14] = mk(1, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_model();
    // Requests during the sweep must be dropped.
    cur = '{1'b1, 1'b1, 1'b0, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 2'd3};
    rst_n = 1;
    count_busy();
    read_all_b();
    for (int k = 0; k < 15; k++) begin
      cur = tbl[k].i;
      cyc();
      cmp($sformatf("vec%0d_doa", k), 0, 8'(doa_q[0]), 8'(tbl[k].xa));
      cmp($sformatf("vec%0d_dob", k), 0, 8'(dob_q[0]), 8'(tbl[k].xb));
      cmp($sformatf("vec%0d_coll", k), 0, 8'(coll_q[0]), 8'(tbl[k].xc));
    end
    cur = '0; cur.ena = 1; cur.addra = 3;
    cyc();
    cur.wea = 1; cur.addra = 10; cur.dia = 1;
    cyc();
    cmp("wf_doa", 0, 8'(doa_q[0]), 8'd1);
    cmp("nc_doa", 2, 8'(doa_q[2]), 8'd1);
    cur = '0;
    cyc();
    cmp("rf_doa_reg", 1, 8'(doa_q[1]), 8'd0);
    for (int k = 0; k < 400; k++) begin
      cur.ena = $urandom_range(0, 3) != 0;
      cur.wea = $urandom_range(0, 1) != 0;
      cur.ssra = $urandom_range(0, 7) == 0;
      cur.addra = 4'($urandom_range(0, 15));
      cur.dia = $urandom_range(0, 1) != 0;
      cur.enb = $urandom_range(0, 3) != 0;
      cur.web = $urandom_range(0, 1) != 0;
      cur.ssrb = $urandom_range(0, 7) == 0;
      cur.addrb = $urandom_range(0, 1) != 0 ? cur.addra[3:1] : 3'($urandom_range(0, 7));
      cur.dib = 2'($urandom_range(0, 3));
      cyc();
    end
    cur = '0;
    cyc();
    rst_n = 0;
    model_reset();
    #1 check_model();
    repeat (2) cyc();
    rst_n = 1;
    repeat (9) cyc();
    rst_n = 0;
    model_reset();
    #1 check_model();
    repeat (2) cyc();
    rst_n = 1;
    count_busy();
    read_all_b();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
